// File: rtl/ram_sync_clr.sv
// Simple-dual-port RAM with inverted bit-write mask, registered read and a clear sweeper.
// Optional macro RAM_SYNC_CLR_BYPASS_EN turns same-address read/write into WRITE_FIRST.
module ram_sync_clr #(
  parameter int              WIDTH      = 16,
  parameter int              DEPTH      = 256,
  parameter int              ADDR_W     = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic              CLKIN,
  input  logic              RESETN,
  input  logic              CLR,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [WIDTH-1:0]  WDATA,
  input  logic [WIDTH-1:0]  MASK,
  input  logic              RE,
  input  logic [ADDR_W-1:0] RADDR,
  output logic [WIDTH-1:0]  RDATA,
  output logic              RVALID,
  output logic              BUSY
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              waddr_ok;
  logic              raddr_ok;
  logic              wr_fire;
  logic              rd_fire;
  logic [WIDTH-1:0]  rd_word;

  // Only a non-power-of-two depth leaves unbacked addresses.
  if ((1 << ADDR_W) == DEPTH) begin : g_pow2
    assign waddr_ok = 1'b1;
    assign raddr_ok = 1'b1;
  end else begin : g_npow2
    assign waddr_ok = (32'(WADDR) < DEPTH);
    assign raddr_ok = (32'(RADDR) < DEPTH);
  end

  assign wr_fire = (state == ST_IDLE) && !CLR && WE && waddr_ok;
  assign rd_fire = (state == ST_IDLE) && !CLR && RE;

  always_comb begin
    rd_word = '0;
    if (raddr_ok) begin
`ifdef RAM_SYNC_CLR_BYPASS_EN
      if (wr_fire && (WADDR == RADDR))
        rd_word = (mem[RADDR] & MASK) | (WDATA & ~MASK);
      else
        rd_word = mem[RADDR];
`else
      rd_word = mem[RADDR];
`endif
    end
  end

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state <= ST_CLEAR;
      ptr   <= '0;
      BUSY  <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (CLR) begin
            ptr <= '0;
          end else if (ptr == LAST) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        ST_IDLE: begin
          if (CLR) begin
            state <= ST_CLEAR;
            BUSY  <= 1'b1;
            ptr   <= '0;
          end
        end
        default: begin
          state <= ST_CLEAR;
          BUSY  <= 1'b1;
          ptr   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      RDATA  <= '0;
      RVALID <= 1'b0;
    end else begin
      RVALID <= rd_fire;
      if (rd_fire)
        RDATA <= rd_word;
    end
  end

  // Array itself has no reset; the sweep gives it a defined value.
  always_ff @(posedge CLKIN) begin
    if (state == ST_CLEAR) begin
      mem[ptr] <= INIT_VALUE;
    end else if (wr_fire) begin
      for (int i = 0; i < WIDTH; i++)
        if (!MASK[i])
          mem[WADDR][i] <= WDATA[i];
    end
  end

endmodule

// File: tb/tb_ram_sync_clr.sv
// Directed bench: a 256-word instance with INIT 16'hA5A5 and a 100-word instance.
module tb_ram_sync_clr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        clr = 1'b0, we = 1'b0, re = 1'b0;
  logic [7:0]  waddr = '0, raddr = '0;
  logic [15:0] wdata = '0, mask = '0;
  logic [15:0] rdata;
  logic        rvalid, busy;

  logic        b_clr = 1'b0, b_we = 1'b0, b_re = 1'b0;
  logic [6:0]  b_waddr = '0, b_raddr = '0;
  logic [15:0] b_wdata = '0, b_mask = '0;
  logic [15:0] b_rdata;
  logic        b_rvalid, b_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ram_sync_clr #(.WIDTH(16), .DEPTH(256), .INIT_VALUE(16'hA5A5)) u_dut_a (
    .CLKIN(clk), .RESETN(rst_n), .CLR(clr), .WE(we), .WADDR(waddr), .WDATA(wdata),
    .MASK(mask), .RE(re), .RADDR(raddr), .RDATA(rdata), .RVALID(rvalid), .BUSY(busy)
  );

  ram_sync_clr #(.WIDTH(16), .DEPTH(100), .INIT_VALUE(16'h00FF)) u_dut_b (
    .CLKIN(clk), .RESETN(rst_n), .CLR(b_clr), .WE(b_we), .WADDR(b_waddr), .WDATA(b_wdata),
    .MASK(b_mask), .RE(b_re), .RADDR(b_raddr), .RDATA(b_rdata), .RVALID(b_rvalid), .BUSY(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts rising edges until each BUSY falls; -1 means it never did.
  task automatic wait_sweep(output int na, output int nb);
    na = -1;
    nb = -1;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk);
      #1;
      if (na < 0 && !busy)   na = n;
      if (nb < 0 && !b_busy) nb = n;
      if (na >= 0 && nb >= 0) break;
    end
  endtask

  task automatic rd_a(input logic [7:0] addr, output logic [15:0] data, output logic valid);
    @(negedge clk);
    re = 1'b1; raddr = addr;
    @(posedge clk);
    #1;
    data = rdata; valid = rvalid;
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic wr_a(input logic [7:0] addr, input logic [15:0] data, input logic [15:0] m);
    @(negedge clk);
    we = 1'b1; waddr = addr; wdata = data; mask = m;
    @(negedge clk);
    we = 1'b0; mask = '0;
  endtask

  task automatic rd_b(input logic [6:0] addr, output logic [15:0] data, output logic valid);
    @(negedge clk);
    b_re = 1'b1; b_raddr = addr;
    @(posedge clk);
    #1;
    data = b_rdata; valid = b_rvalid;
    @(negedge clk);
    b_re = 1'b0;
  endtask

  task automatic wr_b(input logic [6:0] addr, input logic [15:0] data);
    @(negedge clk);
    b_we = 1'b1; b_waddr = addr; b_wdata = data; b_mask = '0;
    @(negedge clk);
    b_we = 1'b0;
  endtask

  initial begin
    int na, nb;
    logic [15:0] d;
    logic v;
    logic [7:0] addr_list [3];
    logic [15:0] coll_exp;
    addr_list[0] = 8'd0; addr_list[1] = 8'd128; addr_list[2] = 8'd255;

    repeat (3) @(negedge clk);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);

    rst_n = 1'b1;
    wait_sweep(na, nb);
    check("sweep_len_256", 32'(na), 32'd256);
    check("sweep_len_100", 32'(nb), 32'd100);

    foreach (addr_list[k]) begin
      rd_a(addr_list[k], d, v);
      check($sformatf("init_rd_%0d", addr_list[k]), 32'(d), 32'hA5A5);
      check($sformatf("init_vld_%0d", addr_list[k]), 32'(v), 32'h1);
    end
    @(posedge clk); #1;
    check("rvalid_drop", 32'(rvalid), 32'h0);
    check("rdata_hold", 32'(rdata), 32'hA5A5);

    wr_a(8'd5, 16'hFFFF, 16'hFF00);
    rd_a(8'd5, d, v);
    check("masked_wr", 32'(d), 32'hA5FF);

    // Collision: write and read the same word in one cycle.
`ifdef RAM_SYNC_CLR_BYPASS_EN
    coll_exp = 16'h1234;
`else
    coll_exp = 16'hA5A5;
`endif
    @(negedge clk);
    we = 1'b1; waddr = 8'd7; wdata = 16'h1234; mask = '0;
    re = 1'b1; raddr = 8'd7;
    @(posedge clk); #1;
    check("collision_rd", 32'(rdata), 32'(coll_exp));
    check("collision_vld", 32'(rvalid), 32'h1);
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    rd_a(8'd7, d, v);
    check("after_collision", 32'(d), 32'h1234);

    // Different addresses in the same cycle stay independent.
    @(negedge clk);
    we = 1'b1; waddr = 8'd9; wdata = 16'h5555; mask = '0;
    re = 1'b1; raddr = 8'd5;
    @(posedge clk); #1;
    check("indep_rd", 32'(rdata), 32'hA5FF);
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    rd_a(8'd9, d, v);
    check("indep_wr", 32'(d), 32'h5555);

    // CLR beats a simultaneous write and read.
    @(negedge clk);
    clr = 1'b1; we = 1'b1; waddr = 8'd3; wdata = 16'h0000; mask = '0;
    re = 1'b1; raddr = 8'd9;
    @(posedge clk); #1;
    check("clr_busy", 32'(busy), 32'h1);
    check("clr_rvalid", 32'(rvalid), 32'h0);
    check("clr_rdata_hold", 32'(rdata), 32'h5555);
    @(negedge clk);
    clr = 1'b0; we = 1'b0; re = 1'b0;
    wait_sweep(na, nb);
    check("clr_sweep_len", 32'(na), 32'd256);
    rd_a(8'd3, d, v);
    check("clr_addr3", 32'(d), 32'hA5A5);
    rd_a(8'd7, d, v);
    check("clr_addr7", 32'(d), 32'hA5A5);

    // Non-power-of-two depth.
    rd_b(7'd99, d, v);
    check("b_init_99", 32'(d), 32'h00FF);
    wr_b(7'd120, 16'hBEEF);
    rd_b(7'd120, d, v);
    check("b_oor_rdata", 32'(d), 32'h0);
    check("b_oor_rvalid", 32'(v), 32'h1);
    wr_b(7'd99, 16'h1357);
    rd_b(7'd99, d, v);
    check("b_wr_99", 32'(d), 32'h1357);
    check("b_vld_99", 32'(v), 32'h1);

    // Reads ignored mid-sweep, then reset mid-sweep.
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (20) @(negedge clk);
    re = 1'b1; raddr = 8'd0;
    @(posedge clk); #1;
    check("busy_rd_ignored", 32'(rvalid), 32'h0);
    check("busy_rdata_hold", 32'(rdata), 32'hA5A5);
    @(negedge clk);
    re = 1'b0;
    repeat (28) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rdata", 32'(rdata), 32'h0);
    check("midrst_rvalid", 32'(rvalid), 32'h0);
    check("midrst_busy", 32'(busy), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_sweep(na, nb);
    check("midrst_sweep_len", 32'(na), 32'd256);
    rd_a(8'd9, d, v);
    check("midrst_final_rd", 32'(d), 32'hA5A5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
